// File: rtl/arm_fetch_pkg.sv
// arm_fetch_pkg: shared types, constants and a saturating-add helper for the fetch queue.
package arm_fetch_pkg;
   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;
   localparam int INSTR_BYTES  = 4;
   localparam int FETCH_PERF_W = 32;
   function automatic logic [FETCH_PERF_W-1:0] sat_add(input logic [FETCH_PERF_W-1:0] a,
                                                       input logic [FETCH_PERF_W-1:0] b);
      logic [FETCH_PERF_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[FETCH_PERF_W] ? '1 : s[FETCH_PERF_W-1:0];
   endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular buffer of {pc, instr} with occupancy count and a flush that empties it.
module fetch_fifo
   import arm_fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  fetch_entry_t               wdata,
   output fetch_entry_t               rdata,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   fetch_entry_t mem [DEPTH];
   logic [AW-1:0] rd_q, wr_q;
   logic [CW-1:0] cnt_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else if (flush) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + 1'b1;
         if (pop) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
   end
   // Storage needs no reset: an empty queue never exposes it.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_q] <= wdata;
   end
   assign rdata = mem[rd_q];
   assign count = cnt_q;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC, imem request and {pc, instr} buffering with valid/ready pop and redirect flush.
// Define FETCH_PERF_EN to add saturating fetched/flushed/stall counters.
module fetch_queue
   import arm_fetch_pkg::*;
#(
   parameter int           N        = 64,
   parameter int           DEPTH    = 4,
   parameter logic [N-1:0] RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       redirect_valid,
   input  logic [N-1:0]               redirect_pc,
   output logic [N-1:0]               IM_addr,
   output logic                       IM_enable,
   input  logic [31:0]                IM_readData,
   input  logic                       deq_ready,
   output logic                       deq_valid,
   output logic [31:0]                deq_instr,
   output logic [N-1:0]               deq_pc,
   output logic [$clog2(DEPTH+1)-1:0] queue_count
`ifdef FETCH_PERF_EN
  ,output logic [FETCH_PERF_W-1:0]    perf_fetched,
   output logic [FETCH_PERF_W-1:0]    perf_flushed,
   output logic [FETCH_PERF_W-1:0]    perf_stall
`endif
);
   localparam int CW = $clog2(DEPTH+1);
   logic [N-1:0] fetch_pc_q, fetch_pc_d;
   fetch_entry_t head_q, head_d, rdata, wdata;
   logic push, pop, nonempty;
   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (redirect_valid),
      .push  (push),
      .pop   (pop),
      .wdata (wdata),
      .rdata (rdata),
      .count (queue_count)
   );
   // Gating push with reset keeps IM_enable low while reset is held.
   always_comb begin
      nonempty   = queue_count != '0;
      deq_valid  = nonempty & ~redirect_valid;
      pop        = deq_valid & deq_ready;
      push       = reset & ~redirect_valid & ((queue_count < CW'(DEPTH)) | pop);
      IM_enable  = push;
      IM_addr    = fetch_pc_q;
      wdata      = '{pc: 64'(fetch_pc_q), instr: IM_readData};
      head_d     = nonempty ? rdata : head_q;
      deq_instr  = head_d.instr;
      deq_pc     = head_d.pc[N-1:0];
      fetch_pc_d = redirect_valid ? (redirect_pc & ~N'(3)) :
                   push ? fetch_pc_q + N'(INSTR_BYTES) : fetch_pc_q;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q <= RESET_PC;
         head_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         head_q     <= head_d;
      end
   end
`ifdef FETCH_PERF_EN
   logic [FETCH_PERF_W-1:0] fetched_q, flushed_q, stall_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetched_q <= '0;
         flushed_q <= '0;
         stall_q   <= '0;
      end else begin
         fetched_q <= sat_add(fetched_q, FETCH_PERF_W'(push));
         flushed_q <= redirect_valid ? sat_add(flushed_q, FETCH_PERF_W'(queue_count)) : flushed_q;
         stall_q   <= sat_add(stall_q, FETCH_PERF_W'(deq_valid & ~deq_ready));
      end
   end
   assign perf_fetched = fetched_q;
   assign perf_flushed = flushed_q;
   assign perf_stall   = stall_q;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table vectors, directed corner sequences and random traffic against a queue model.
module tb_fetch_queue;
   logic        clk = 1'b0, reset = 1'b0, redirect_valid = 1'b0, deq_ready = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic [63:0] IM_addr, deq_pc;
   logic        IM_enable, deq_valid;
   logic [31:0] IM_readData, deq_instr;
   logic [2:0]  queue_count;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_flushed, perf_stall;
   logic [31:0] flushed_before;
`endif
   int total = 0, bad = 0;

   fetch_queue dut (
      .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .IM_addr(IM_addr), .IM_enable(IM_enable), .IM_readData(IM_readData),
      .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_instr(deq_instr), .deq_pc(deq_pc),
      .queue_count(queue_count)
`ifdef FETCH_PERF_EN
     ,.perf_fetched(perf_fetched), .perf_flushed(perf_flushed), .perf_stall(perf_stall)
`endif
   );

   always #5 clk = ~clk;
   assign IM_readData = IM_addr[31:0];

   typedef struct {logic [63:0] pc; logic [31:0] instr;} ent_t;
   ent_t        q[$];
   logic [63:0] mpc;

   typedef struct {
      logic rdy; logic v; logic [63:0] pc; int cnt; logic en; logic [63:0] addr;
   } vec_t;
   vec_t tv[13];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_model();
      logic ev, pop;
      ev  = q.size() != 0 && !redirect_valid;
      pop = ev && deq_ready;
      chk("valid", 64'(deq_valid), 64'(ev));
      chk("count", 64'(queue_count), 64'(q.size()));
      chk("im_en", 64'(IM_enable), 64'(!redirect_valid && (q.size() < 4 || pop)));
      chk("im_addr", IM_addr, mpc);
      if (ev) begin
         chk("head_pc", deq_pc, q[0].pc);
         chk("head_instr", 64'(deq_instr), 64'(q[0].instr));
      end
   endtask

   task automatic cycle(input logic rv, input logic [63:0] rp, input logic rdy);
      logic pop, push;
      redirect_valid = rv;
      redirect_pc    = rp;
      deq_ready      = rdy;
      #2 check_model();
      pop  = q.size() != 0 && !rv && rdy;
      push = !rv && (q.size() < 4 || pop);
      @(posedge clk);
      if (rv) begin
         q.delete();
         mpc = {rp[63:2], 2'b00};
      end else begin
         if (pop) void'(q.pop_front());
         if (push) begin
            q.push_back('{mpc, mpc[31:0]});
            mpc = mpc + 64'd4;
         end
      end
      @(negedge clk);
      redirect_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      redirect_valid = 1'b0;
      deq_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      q.delete();
      mpc = '0;
   endtask

   initial begin
      tv[0]  = '{1'b0, 1'b0, 64'h0,  0, 1'b1, 64'h0};
      tv[1]  = '{1'b0, 1'b1, 64'h0,  1, 1'b1, 64'h4};
      tv[2]  = '{1'b0, 1'b1, 64'h0,  2, 1'b1, 64'h8};
      tv[3]  = '{1'b0, 1'b1, 64'h0,  3, 1'b1, 64'hC};
      tv[4]  = '{1'b0, 1'b1, 64'h0,  4, 1'b0, 64'h10};
      tv[5]  = '{1'b0, 1'b1, 64'h0,  4, 1'b0, 64'h10};
      tv[6]  = '{1'b0, 1'b1, 64'h0,  4, 1'b0, 64'h10};
      tv[7]  = '{1'b0, 1'b1, 64'h0,  4, 1'b0, 64'h10};
      tv[8]  = '{1'b1, 1'b1, 64'h0,  4, 1'b1, 64'h10};
      tv[9]  = '{1'b1, 1'b1, 64'h4,  4, 1'b1, 64'h14};
      tv[10] = '{1'b1, 1'b1, 64'h8,  4, 1'b1, 64'h18};
      tv[11] = '{1'b1, 1'b1, 64'hC,  4, 1'b1, 64'h1C};
      tv[12] = '{1'b1, 1'b1, 64'h10, 4, 1'b1, 64'h20};
      #2;
      chk("rst_valid", 64'(deq_valid), 64'd0);
      chk("rst_count", 64'(queue_count), 64'd0);
      chk("rst_im_en", 64'(IM_enable), 64'd0);
      chk("rst_pc", deq_pc, 64'd0);
      chk("rst_instr", 64'(deq_instr), 64'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 13; i++) begin
         deq_ready = tv[i].rdy;
         #2;
         chk($sformatf("tv%0d_valid", i), 64'(deq_valid), 64'(tv[i].v));
         chk($sformatf("tv%0d_count", i), 64'(queue_count), 64'(tv[i].cnt));
         chk($sformatf("tv%0d_im_en", i), 64'(IM_enable), 64'(tv[i].en));
         chk($sformatf("tv%0d_addr", i), IM_addr, tv[i].addr);
         if (tv[i].v) begin
            chk($sformatf("tv%0d_pc", i), deq_pc, tv[i].pc);
            chk($sformatf("tv%0d_instr", i), 64'(deq_instr), 64'(tv[i].pc[31:0]));
         end
         @(posedge clk);
         @(negedge clk);
      end
      do_reset();
      repeat (6) cycle(1'b0, '0, 1'b1);
      repeat (5) cycle(1'b0, '0, 1'b0);
      repeat (6) cycle(1'b0, '0, 1'b1);
      do_reset();
      repeat (3) cycle(1'b0, '0, 1'b0);
`ifdef FETCH_PERF_EN
      flushed_before = perf_flushed;
`endif
      cycle(1'b1, 64'h107, 1'b1);
      #1 chk("redir_addr", IM_addr, 64'h104);
      chk("redir_count", 64'(queue_count), 64'd0);
`ifdef FETCH_PERF_EN
      chk("perf_flushed", 64'(perf_flushed - flushed_before), 64'd3);
`endif
      repeat (4) cycle(1'b0, '0, 1'b1);
      do_reset();
      repeat (2) cycle(1'b0, '0, 1'b0);
      #2 reset = 1'b0;
      #1;
      chk("arst_valid", 64'(deq_valid), 64'd0);
      chk("arst_count", 64'(queue_count), 64'd0);
      chk("arst_im_en", 64'(IM_enable), 64'd0);
      chk("arst_pc", deq_pc, 64'd0);
      chk("arst_instr", 64'(deq_instr), 64'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      q.delete();
      mpc = '0;
      repeat (4) cycle(1'b0, '0, 1'b1);
      cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
      cycle(1'b0, '0, 1'b0);
      #1 chk("wrap_addr", IM_addr, 64'h0);
      repeat (10) cycle(1'b0, '0, 1'b1);
      repeat (400)
         cycle($urandom_range(0, 19) == 0, {$urandom, $urandom}, $urandom_range(0, 3) != 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
